// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores over a valid/ready bus and holds the result for write-back.
// Optional misaligned-access trap enabled by defining MEMORY_STAGE_MISALIGN_TRAP_EN.
module memory_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] valE,
    input  logic [XLEN-1:0] valS,
    input  logic            mem_read_en,
    input  logic            mem_write_en,
    input  logic [2:0]      mem_width,
    input  logic [4:0]      rd_in,
    input  logic            wb_en_in,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] valM,
    output logic [XLEN-1:0] valE_out,
    output logic [4:0]      rd_out,
    output logic            wb_en_out,
    output logic            misalign
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    function automatic logic [3:0] store_strb(input logic [2:0] w, input logic [1:0] off);
        case (w[1:0])
            2'b00:   store_strb = 4'b0001 << off;
            2'b01:   store_strb = 4'b0011 << {off[1], 1'b0};
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] w, input logic [31:0] s);
        case (w[1:0])
            2'b00:   store_data = {4{s[7:0]}};
            2'b01:   store_data = {2{s[15:0]}};
            default: store_data = s;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] w, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (w)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = rdata;
        endcase
    endfunction

    logic [1:0]      state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] valM_q, valM_d;
    logic [XLEN-1:0] valE_out_q, valE_out_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic            wb_en_out_q, wb_en_out_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            we_q, we_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] lat_valE_q, lat_valE_d;
    logic [2:0]      lat_width_q, lat_width_d;
    logic [4:0]      lat_rd_q, lat_rd_d;
    logic            lat_wb_q, lat_wb_d;

    logic accept, is_mem, trap;

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mem   = mem_read_en || mem_write_en;

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    assign trap = is_mem && (((mem_width[1:0] == 2'b01) && valE[0]) ||
                             ((mem_width == 3'b010) && (valE[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        valM_d      = valM_q;
        valE_out_d  = valE_out_q;
        rd_out_d    = rd_out_q;
        wb_en_out_d = wb_en_out_q;
        misalign_d  = misalign_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        lat_valE_d  = lat_valE_q;
        lat_width_d = lat_width_q;
        lat_rd_d    = lat_rd_q;
        lat_wb_d    = lat_wb_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            misalign_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && (!is_mem || trap)) begin
                    // Non-memory and trapped ops complete directly from IDLE.
                    out_valid_d = 1'b1;
                    valM_d      = '0;
                    valE_out_d  = valE;
                    rd_out_d    = rd_in;
                    wb_en_out_d = wb_en_in && !trap;
                    misalign_d  = trap;
                end else if (accept) begin
                    state_d     = S_REQ;
                    addr_d      = {valE[XLEN-1:2], 2'b00};
                    we_d        = mem_write_en;
                    wstrb_d     = mem_write_en ? store_strb(mem_width, valE[1:0]) : 4'b0000;
                    wdata_d     = mem_write_en ? store_data(mem_width, valS) : '0;
                    lat_valE_d  = valE;
                    lat_width_d = mem_width;
                    lat_rd_d    = rd_in;
                    lat_wb_d    = wb_en_in;
                end
            end
            S_REQ: begin
                if (dmem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dmem_rsp_valid) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    valM_d      = we_q ? '0 : load_ext(lat_width_q, lat_valE_q[1:0], dmem_rdata);
                    valE_out_d  = lat_valE_q;
                    rd_out_d    = lat_rd_q;
                    wb_en_out_d = lat_wb_q;
                    misalign_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            valM_q      <= '0;
            valE_out_q  <= '0;
            rd_out_q    <= '0;
            wb_en_out_q <= 1'b0;
            misalign_q  <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            lat_valE_q  <= '0;
            lat_width_q <= '0;
            lat_rd_q    <= '0;
            lat_wb_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            valM_q      <= valM_d;
            valE_out_q  <= valE_out_d;
            rd_out_q    <= rd_out_d;
            wb_en_out_q <= wb_en_out_d;
            misalign_q  <= misalign_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            lat_valE_q  <= lat_valE_d;
            lat_width_q <= lat_width_d;
            lat_rd_q    <= lat_rd_d;
            lat_wb_q    <= lat_wb_d;
        end
    end

    assign dmem_req_valid = (state_q == S_REQ);
    assign dmem_addr      = addr_q;
    assign dmem_we        = we_q;
    assign dmem_wstrb     = wstrb_q;
    assign dmem_wdata     = wdata_q;
    assign out_valid      = out_valid_q;
    assign valM           = valM_q;
    assign valE_out       = valE_out_q;
    assign rd_out         = rd_out_q;
    assign wb_en_out      = wb_en_out_q;
    assign misalign       = misalign_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads, stores, back-pressure, ALU streaming, reset, misalign.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] valE, valS;
    logic        mem_read_en, mem_write_en;
    logic [2:0]  mem_width;
    logic [4:0]  rd_in;
    logic        wb_en_in;
    logic        dmem_req_valid, dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] valM, valE_out;
    logic [4:0]  rd_out;
    logic        wb_en_out, misalign;

    int total = 0;
    int bad   = 0;

    memory_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .valE(valE), .valS(valS), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_width(mem_width), .rd_in(rd_in), .wb_en_in(wb_en_in),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .valM(valM), .valE_out(valE_out),
        .rd_out(rd_out), .wb_en_out(wb_en_out), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [31:0] e, input logic [31:0] s,
                          input logic re, input logic we, input logic [2:0] w,
                          input logic [4:0] rd, input logic wb);
        in_valid = v; valE = e; valS = s; mem_read_en = re; mem_write_en = we;
        mem_width = w; rd_in = rd; wb_en_in = wb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_op(0, 0, 0, 0, 0, 3'b000, 0, 0);
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0; out_ready = 1;
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%h exp=0", out_valid); end
        total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%h exp=0", dmem_req_valid); end
        total++; if ({valM, valE_out, dmem_addr, dmem_wdata} !== 128'd0) begin bad++; $display("FAIL rst_data got=%h/%h/%h/%h exp=0", valM, valE_out, dmem_addr, dmem_wdata); end
        total++; if ({rd_out, wb_en_out, dmem_we, dmem_wstrb, misalign} !== 12'd0) begin bad++; $display("FAIL rst_ctrl got=%h exp=0", {rd_out, wb_en_out, dmem_we, dmem_wstrb, misalign}); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%h exp=1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load(input logic [31:0] e, input logic [2:0] w, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [31:0] exp_valM);
        set_op(1, e, 32'h0, 1, 0, w, 5'd5, 1);
        tick();
        set_op(0, 0, 0, 0, 0, 3'b000, 0, 0);
        total++; if (dmem_req_valid !== 1'b1) begin bad++; $display("FAIL ld_req_valid got=%h exp=1", dmem_req_valid); end
        total++; if (dmem_addr !== exp_addr) begin bad++; $display("FAIL ld_addr got=%h exp=%h", dmem_addr, exp_addr); end
        total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL ld_we got=%h exp=0", dmem_we); end
        dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0;
        total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL ld_req_drop got=%h exp=0", dmem_req_valid); end
        dmem_rsp_valid = 1; dmem_rdata = rdata;
        tick();
        dmem_rsp_valid = 0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ld_out_valid got=%h exp=1", out_valid); end
        total++; if (valM !== exp_valM) begin bad++; $display("FAIL ld_valM got=%h exp=%h", valM, exp_valM); end
        total++; if ({valE_out, rd_out, wb_en_out} !== {e, 5'd5, 1'b1}) begin bad++; $display("FAIL ld_fields got=%h/%h/%h exp=%h/5/1", valE_out, rd_out, wb_en_out, e); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ld_out_clear got=%h exp=0", out_valid); end
    endtask

    task automatic test_half_store();
        set_op(1, 32'h0000_2002, 32'h1234_ABCD, 0, 1, 3'b001, 5'd0, 0);
        tick();
        set_op(0, 0, 0, 0, 0, 3'b000, 0, 0);
        total++; if ({dmem_req_valid, dmem_we} !== 2'b11) begin bad++; $display("FAIL st_req got=%b exp=11", {dmem_req_valid, dmem_we}); end
        total++; if (dmem_addr !== 32'h0000_2000) begin bad++; $display("FAIL st_addr got=%h exp=00002000", dmem_addr); end
        total++; if (dmem_wstrb !== 4'b1100) begin bad++; $display("FAIL st_wstrb got=%b exp=1100", dmem_wstrb); end
        total++; if (dmem_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL st_wdata got=%h exp=abcdabcd", dmem_wdata); end
        dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_rsp_valid = 0;
        total++; if ({out_valid, valM} !== {1'b1, 32'h0}) begin bad++; $display("FAIL st_valM got=%h/%h exp=1/0", out_valid, valM); end
        tick();
    endtask

    task automatic test_backpressure();
        set_op(1, 32'h0000_4000, 0, 1, 0, 3'b010, 5'd9, 1);
        tick();
        set_op(1, 32'h0000_0055, 0, 0, 0, 3'b000, 5'd7, 1);
        for (int i = 0; i < 3; i++) begin
            total++; if ({dmem_req_valid, dmem_we, in_ready} !== 3'b100) begin bad++; $display("FAIL bp_req%0d got=%b exp=100", i, {dmem_req_valid, dmem_we, in_ready}); end
            total++; if (dmem_addr !== 32'h0000_4000) begin bad++; $display("FAIL bp_addr%0d got=%h exp=00004000", i, dmem_addr); end
            tick();
        end
        dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rdata = 32'hDEAD_BEEF; out_ready = 0;
        tick();
        dmem_rsp_valid = 0; dmem_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL bp_hold%0d got=%b exp=10", i, {out_valid, in_ready}); end
            total++; if ({valM, rd_out} !== {32'hDEAD_BEEF, 5'd9}) begin bad++; $display("FAIL bp_valM%0d got=%h/%h exp=deadbeef/9", i, valM, rd_out); end
            tick();
        end
        out_ready = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%h exp=1", in_ready); end
        tick();
        set_op(0, 0, 0, 0, 0, 3'b000, 0, 0);
        total++; if ({out_valid, valE_out, valM, rd_out} !== {1'b1, 32'h55, 32'h0, 5'd7}) begin bad++; $display("FAIL bp_b2b got=%h/%h/%h/%h exp=1/55/0/7", out_valid, valE_out, valM, rd_out); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_clear got=%h exp=0", out_valid); end
    endtask

    task automatic test_nonmem_stream();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            set_op(1, vals[i], 0, 0, 0, 3'b000, 5'(i + 1), 1);
            tick();
            total++; if ({out_valid, dmem_req_valid} !== 2'b10) begin bad++; $display("FAIL alu_valid%0d got=%b exp=10", i, {out_valid, dmem_req_valid}); end
            total++; if ({valE_out, valM, rd_out} !== {vals[i], 32'h0, 5'(i + 1)}) begin bad++; $display("FAIL alu_data%0d got=%h/%h/%h exp=%h/0/%0d", i, valE_out, valM, rd_out, vals[i], i + 1); end
        end
        set_op(0, 0, 0, 0, 0, 3'b000, 0, 0);
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL alu_clear got=%h exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        set_op(1, 32'h0000_1000, 0, 1, 0, 3'b010, 5'd3, 1);
        tick();
        set_op(0, 0, 0, 0, 0, 3'b000, 0, 0);
        total++; if (dmem_req_valid !== 1'b1) begin bad++; $display("FAIL rm_req got=%h exp=1", dmem_req_valid); end
        rst_n = 0;
        #1;
        total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL rm_async_drop got=%h exp=0", dmem_req_valid); end
        rst_n = 1;
        tick();
        set_op(1, 32'h0000_1000, 0, 1, 0, 3'b010, 5'd3, 1);
        tick();
        set_op(0, 0, 0, 0, 0, 3'b000, 0, 0);
        dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0;
        rst_n = 0;
        tick();
        rst_n = 1; dmem_rsp_valid = 1; dmem_rdata = 32'h1234_5678;
        tick();
        dmem_rsp_valid = 0;
        total++; if ({out_valid, in_ready, dmem_req_valid} !== 3'b010) begin bad++; $display("FAIL rm_stale got=%b exp=010", {out_valid, in_ready, dmem_req_valid}); end
    endtask

    task automatic test_misalign();
        set_op(1, 32'h0000_3001, 0, 1, 0, 3'b010, 5'd4, 1);
        tick();
        set_op(0, 0, 0, 0, 0, 3'b000, 0, 0);
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
        total++; if ({dmem_req_valid, out_valid, misalign, wb_en_out} !== 4'b0110) begin bad++; $display("FAIL mis_trap got=%b exp=0110", {dmem_req_valid, out_valid, misalign, wb_en_out}); end
        total++; if (valM !== 32'h0) begin bad++; $display("FAIL mis_valM got=%h exp=0", valM); end
        tick();
        total++; if ({out_valid, misalign} !== 2'b00) begin bad++; $display("FAIL mis_clear got=%b exp=00", {out_valid, misalign}); end
`else
        total++; if ({dmem_req_valid, dmem_addr} !== {1'b1, 32'h0000_3000}) begin bad++; $display("FAIL mis_addr got=%h/%h exp=1/00003000", dmem_req_valid, dmem_addr); end
        dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_rsp_valid = 0;
        total++; if ({out_valid, misalign, valM} !== {2'b10, 32'hCAFE_F00D}) begin bad++; $display("FAIL mis_valM got=%h/%h/%h exp=1/0/cafef00d", out_valid, misalign, valM); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_load(32'h0000_1003, 3'b000, 32'h80FF_0000, 32'h0000_1000, 32'hFFFF_FF80);
        test_load(32'h0000_1003, 3'b100, 32'h80FF_0000, 32'h0000_1000, 32'h0000_0080);
        test_load(32'h0000_1002, 3'b001, 32'h80FF_0000, 32'h0000_1000, 32'hFFFF_80FF);
        test_half_store();
        test_backpressure();
        test_nonmem_stream();
        test_reset_mid();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of execute_stage; consumes valE (ALU result / effective address) plus the store operand and the decoded memory controls.
- Performs loads and stores through a valid/ready data-memory port, then forwards the results (valM, valE, rd) to write-back.
- Multi-cycle: an FSM issues the bus request, waits for the response, and holds the result until write-back accepts it.
- Provides a single-entry output register and back-pressure (in_ready) to execute.

Parameters:
- XLEN, 32, datapath width; only 32 is supported (4 byte lanes).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  execute result valid
- in_ready  output  1  stage can accept a new instruction
- valE  input  XLEN  ALU result / effective address
- valS  input  XLEN  store data (rs2 value)
- mem_read_en  input  1  instruction is a load
- mem_write_en  input  1  instruction is a store
- mem_width  input  3  func3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rd_in  input  5  destination register
- wb_en_in  input  1  register write-back enable
- dmem_req_valid  output  1  bus request valid
- dmem_req_ready  input  1  bus accepts request
- dmem_addr  output  XLEN  word-aligned address ({valE[31:2],2'b00})
- dmem_we  output  1  1 = write
- dmem_wstrb  output  4  byte-lane write strobes
- dmem_wdata  output  XLEN  lane-replicated store data
- dmem_rsp_valid  input  1  read data returned or write acknowledged
- dmem_rdata  input  XLEN  read data word
- out_valid  output  1  result valid to write-back
- out_ready  input  1  write-back accepts the result
- valM  output  XLEN  load result, extended; 0 for non-loads
- valE_out  output  XLEN  registered valE
- rd_out  output  5  registered rd
- wb_en_out  output  1  registered write-back enable
- misalign  output  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - out_valid=0, dmem_req_valid=0, misalign=0.
  - valM, valE_out, rd_out, wb_en_out, dmem_addr, dmem_wdata, dmem_wstrb all 0; dmem_we=0.
- States: IDLE, REQ, WAIT_RSP.
- Acceptance: in_ready = (state==IDLE) && (!out_valid || out_ready). The stage accepts on in_valid && in_ready, latching valE, valS, width, rd, wb_en and the op type.
- Non-memory op:
  - Stays in IDLE.
  - out_valid=1 the next cycle; valM=0.
  - Latency is 1 cycle.
- Memory op:
  - IDLE→REQ. dmem_req_valid=1 from the next cycle, with address, we, wstrb and wdata held stable until dmem_req_ready.
  - REQ→WAIT_RSP on dmem_req_ready. dmem_req_valid drops in that same transition.
  - WAIT_RSP→IDLE on dmem_rsp_valid. out_valid=1 the next cycle.
  - Minimum latency is 3 cycles (accept, req, rsp) with zero bus wait.
- The bus returns dmem_rsp_valid no earlier than the cycle after request acceptance. dmem_rsp_valid outside WAIT_RSP is ignored.
- mem_read_en and mem_write_en both set: treated as a store.
- Store lanes (off = valE[1:0]):
  - Byte: wstrb = 4'b0001<<off; wdata = {4{valS[7:0]}}.
  - Half: wstrb = 4'b0011<<{off[1],1'b0}; wdata = {2{valS[15:0]}}.
  - Word: wstrb = 4'b1111; wdata = valS.
- Load extraction:
  - Byte lane = rdata[8*off +: 8]; half lane = rdata[16*off[1] +: 16].
  - 000/001 sign-extend; 100/101 zero-extend; 010 passes the word through.
  - Undefined width codes load the word.
  - For stores, valM=0.
- Output hold: out_valid and all out fields stay stable until out_ready. out_valid clears the cycle after out_valid && out_ready, unless a non-memory op is accepted in the same cycle, in which case the next result is presented back-to-back.
- Reset mid-transaction: the request is abandoned and dmem_req_valid is deasserted immediately. A later stale dmem_rsp_valid is ignored in IDLE.

Optional Feature:
- Macro: MEMORY_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses are trapped: half with off[0]=1, or word with off!=0.
  - A trapped access issues no bus request and stays in IDLE.
  - out_valid=1 the next cycle with misalign=1, valM=0, wb_en_out=0.
  - misalign clears when that output is consumed.
- Undefined:
  - misalign is tied 0.
  - Low address bits are ignored for lane selection: half uses off[1] only, word ignores off.

Test Plan:
- Reset mid-WAIT_RSP: rst_n low for 1 cycle, then stale dmem_rsp_valid=1 → out_valid stays 0, state IDLE, in_ready=1.
- Signed byte load, valE=0x1003, dmem_rdata=0x80FF_0000, width 000 → dmem_addr=0x1000, dmem_we=0, valM=0xFFFF_FF80; width 100 → valM=0x0000_0080.
- Half store, valE=0x2002, valS=0x1234_ABCD, width 001 → dmem_wstrb=4'b1100, dmem_wdata=0xABCD_ABCD, valM=0.
- Back-pressure: dmem_req_ready low for 3 cycles → request fields stable and in_ready=0; then out_ready low for 2 cycles → valM held, no new accept.
- Non-memory stream: 3 consecutive ALU ops with out_ready=1 → out_valid for 3 consecutive cycles, valE_out values in order, dmem_req_valid never asserted.
- With MEMORY_STAGE_MISALIGN_TRAP_EN, word load at valE=0x3001 → no dmem_req_valid, misalign=1, wb_en_out=0 one cycle after accept. Without the macro → dmem_addr=0x3000, valM=dmem_rdata.
